// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared constants and types for the register file/scoreboard
// Revision    : 1.0
// ============================================================================
package regfile_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);

   typedef logic [AW_DEF-1:0]   reg_addr_t;
   typedef logic [XLEN_DEF-1:0] reg_data_t;
endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// regfile_sb_if : decode/write-back side bus of the register file scoreboard
// Revision      : 1.0
// ============================================================================
interface regfile_sb_if import regfile_pkg::*; #(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF
);
   localparam int AW = $clog2(NREGS);

   logic            rd_en;
   logic [AW-1:0]   ra1;
   logic [AW-1:0]   ra2;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic            rdy1;
   logic            rdy2;
   logic            iss_en;
   logic [AW-1:0]   iss_addr;
   logic            we;
   logic [AW-1:0]   wa;
   logic [XLEN-1:0] wd;
   logic [AW:0]     pend_cnt;

   modport master (
      output rd_en, ra1, ra2, iss_en, iss_addr, we, wa, wd,
      input  rd1, rd2, rdy1, rdy2, pend_cnt
   );

   modport slave (
      input  rd_en, ra1, ra2, iss_en, iss_addr, we, wa, wd,
      output rd1, rd2, rdy1, rdy2, pend_cnt
   );
endinterface
`default_nettype wire

// File: rtl/regfile_rport.sv
`default_nettype none
// ============================================================================
// regfile_rport : one registered read port with write-first bypass and ready
// Revision      : 1.0
// ============================================================================
module regfile_rport import regfile_pkg::*; #(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        rdEn,
   input  logic [$clog2(NREGS)-1:0]    ra,
   input  logic                        wrEn,
   input  logic [$clog2(NREGS)-1:0]    wrAddr,
   input  logic [XLEN-1:0]             wrData,
   input  logic [NREGS-1:0][XLEN-1:0]  regs,
   input  logic [NREGS-1:0]            readyNext,
   output logic [XLEN-1:0]             rd,
   output logic                        rdy
);
   logic [XLEN-1:0] w_data;
   logic            w_rdy;
   logic [XLEN-1:0] r_rd;
   logic            r_rdy;

   // wrEn is already masked for the hard-wired zero register by the caller
   assign w_data = (wrEn && (wrAddr == ra)) ? wrData : regs[ra];
   assign w_rdy  = readyNext[ra];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd  <= '0;
         r_rdy <= 1'b1;
      end else if (rdEn) begin
         r_rd  <= w_data;
         r_rdy <= w_rdy;
      end
   end

   assign rd  = r_rd;
   assign rdy = r_rdy;
endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// regfile_sb : 2R/1W register file with per-register ready scoreboard
// Revision   : 1.0
// ============================================================================
module regfile_sb import regfile_pkg::*; #(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int ZERO_REG = 1
) (
   input  logic         clk,
   input  logic         reset,
   regfile_sb_if.slave  bus
);
   localparam int   AW        = $clog2(NREGS);
   localparam logic c_zeroEn  = (ZERO_REG != 0);

   logic [NREGS-1:0][XLEN-1:0] r_regs;
   logic [NREGS-1:0]           r_ready;
   logic [NREGS-1:0]           w_readyNext;
   logic [AW:0]                r_pendCnt;
   logic                       w_weEff;
   logic                       w_issEff;
   logic                       w_inc;
   logic                       w_dec;

   assign w_weEff  = bus.we     && !(c_zeroEn && (bus.wa == '0));
   assign w_issEff = bus.iss_en && !(c_zeroEn && (bus.iss_addr == '0));

   // Issue is applied after write-back so a same-address issue leaves the flag low
   always_comb begin
      w_readyNext = r_ready;
      if (w_weEff)
         w_readyNext[bus.wa] = 1'b1;
      if (w_issEff)
         w_readyNext[bus.iss_addr] = 1'b0;
   end

   assign w_inc = w_issEff && r_ready[bus.iss_addr];
   assign w_dec = w_weEff && !r_ready[bus.wa] &&
                  !(w_issEff && (bus.iss_addr == bus.wa));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_regs    <= '0;
         r_ready   <= '1;
         r_pendCnt <= '0;
      end else begin
         if (w_weEff)
            r_regs[bus.wa] <= bus.wd;
         r_ready   <= w_readyNext;
         r_pendCnt <= r_pendCnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
      end
   end

   assign bus.pend_cnt = r_pendCnt;

   regfile_rport #(.XLEN(XLEN), .NREGS(NREGS)) u_rport1 (
      .clk       (clk),
      .reset     (reset),
      .rdEn      (bus.rd_en),
      .ra        (bus.ra1),
      .wrEn      (w_weEff),
      .wrAddr    (bus.wa),
      .wrData    (bus.wd),
      .regs      (r_regs),
      .readyNext (w_readyNext),
      .rd        (bus.rd1),
      .rdy       (bus.rdy1)
   );

   regfile_rport #(.XLEN(XLEN), .NREGS(NREGS)) u_rport2 (
      .clk       (clk),
      .reset     (reset),
      .rdEn      (bus.rd_en),
      .ra        (bus.ra2),
      .wrEn      (w_weEff),
      .wrAddr    (bus.wa),
      .wrData    (bus.wd),
      .regs      (r_regs),
      .readyNext (w_readyNext),
      .rd        (bus.rd2),
      .rdy       (bus.rdy2)
   );
endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// tb_regfile_sb : randomized + directed bench against an array-based model
// Revision      : 1.0
// ============================================================================
module tb_regfile_sb;
   import regfile_pkg::*;

   logic clk;
   logic reset;

   regfile_sb_if bus ();

   regfile_sb dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nChecks;
   int nPass;

   reg_data_t mRegs  [32];
   bit        mReady [32];
   reg_data_t mRd1, mRd2;
   bit        mRdy1, mRdy2;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs === exp)
         nPass++;
      else
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic int modelPend();
      int n = 0;
      for (int i = 0; i < 32; i++)
         if (!mReady[i]) n++;
      return n;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 32; i++) begin
         mRegs[i]  = '0;
         mReady[i] = 1'b1;
      end
      mRd1 = '0; mRd2 = '0; mRdy1 = 1'b1; mRdy2 = 1'b1;
   endtask

   task automatic checkOutputs(input string tag);
      check({tag, ".rd1"},  64'(bus.rd1),      64'(mRd1));
      check({tag, ".rd2"},  64'(bus.rd2),      64'(mRd2));
      check({tag, ".rdy1"}, 64'(bus.rdy1),     64'(mRdy1));
      check({tag, ".rdy2"}, 64'(bus.rdy2),     64'(mRdy2));
      check({tag, ".pend"}, 64'(bus.pend_cnt), 64'(modelPend()));
   endtask

   // One clock: drive inputs just after an edge, model the edge, sample 1 ns later
   task automatic cyc(input string tag,
                      input bit rde, input reg_addr_t a1, input reg_addr_t a2,
                      input bit iss, input reg_addr_t ia,
                      input bit w, input reg_addr_t a, input reg_data_t d);
      bus.rd_en = rde; bus.ra1 = a1; bus.ra2 = a2;
      bus.iss_en = iss; bus.iss_addr = ia;
      bus.we = w; bus.wa = a; bus.wd = d;
      @(posedge clk);
      if (w && a != 0) begin
         mRegs[a]  = d;
         mReady[a] = 1'b1;
      end
      if (iss && ia != 0)
         mReady[ia] = 1'b0;
      if (rde) begin
         mRd1 = mRegs[a1]; mRdy1 = mReady[a1];
         mRd2 = mRegs[a2]; mRdy2 = mReady[a2];
      end
      #1;
      checkOutputs(tag);
   endtask

   task automatic doReset();
      reset = 1'b1;
      #12;
      reset = 1'b0;
      modelReset();
      @(posedge clk);
      #1;
   endtask

   reg_addr_t rA1, rA2, rIa, rWa;

   initial begin
      nChecks = 0;
      nPass   = 0;
      bus.rd_en = 0; bus.ra1 = '0; bus.ra2 = '0; bus.iss_en = 0;
      bus.iss_addr = '0; bus.we = 0; bus.wa = '0; bus.wd = '0;
      modelReset();
      doReset();
      checkOutputs("reset");

      cyc("rd5_0", 1, 5'd5, 5'd0, 0, 0, 0, 0, 0);
      cyc("iss3",  0, 0, 0, 1, 5'd3, 0, 0, 0);
      cyc("rd3",   1, 5'd3, 5'd0, 0, 0, 0, 0, 0);
      check("iss3.pend1", 64'(bus.pend_cnt), 64'd1);
      cyc("wb3",   1, 5'd3, 5'd0, 0, 0, 1, 5'd3, 32'hDEADBEEF);
      check("wb3.rd1", 64'(bus.rd1), 64'hDEADBEEF);
      cyc("issWb7", 1, 5'd7, 5'd3, 1, 5'd7, 1, 5'd7, 32'h55);
      check("issWb7.rdy1", 64'(bus.rdy1), 64'd0);
      cyc("x0",    1, 5'd0, 5'd7, 1, 5'd0, 1, 5'd0, 32'hFFFFFFFF);
      check("x0.rd1", 64'(bus.rd1), 64'd0);

      for (int i = 1; i < 32; i++)
         cyc("issAll", 1, reg_addr_t'(i), 5'd0, 1, reg_addr_t'(i), 0, 0, 0);
      check("issAll.pend31", 64'(bus.pend_cnt), 64'd31);
      for (int i = 1; i < 32; i++)
         cyc("wbAll", 1, reg_addr_t'(i), reg_addr_t'(32 - i), 0, 0, 1,
             reg_addr_t'(i), $urandom);
      check("wbAll.pend0", 64'(bus.pend_cnt), 64'd0);

      // Random traffic, addresses narrowed at times to force collisions
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            rA1 = reg_addr_t'($urandom_range(0, 3)); rA2 = reg_addr_t'($urandom_range(0, 3));
            rIa = reg_addr_t'($urandom_range(0, 3)); rWa = reg_addr_t'($urandom_range(0, 3));
         end else begin
            rA1 = reg_addr_t'($urandom); rA2 = reg_addr_t'($urandom);
            rIa = reg_addr_t'($urandom); rWa = reg_addr_t'($urandom);
         end
         cyc("rand", 1'($urandom_range(0, 3) != 0), rA1, rA2,
             1'($urandom_range(0, 1)), rIa, 1'($urandom_range(0, 2) == 0), rWa, $urandom);
      end

      // Asynchronous reset pulse with pend_cnt=4 and rd1 nonzero
      doReset();
      cyc("pre.wb5", 0, 0, 0, 0, 0, 1, 5'd5, 32'h1234);
      for (int i = 10; i < 14; i++)
         cyc("pre.iss", 0, 0, 0, 1, reg_addr_t'(i), 0, 0, 0);
      cyc("pre.rd5", 1, 5'd5, 5'd10, 0, 0, 0, 0, 0);
      check("pre.pend4", 64'(bus.pend_cnt), 64'd4);
      check("pre.rd1", 64'(bus.rd1), 64'h1234);
      bus.rd_en = 0; bus.iss_en = 0; bus.we = 0;
      #2 reset = 1'b1;
      #1;
      modelReset();
      checkOutputs("asyncRst");
      #1 reset = 1'b0;
      cyc("postRst", 1, 5'd5, 5'd10, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Parametrised two-read / one-write register file with an integrated per-register scoreboard for the pipelined processor. It sits between decode (read and issue) and write-back. It returns registered source operands together with a per-operand "ready" flag, so the hazard unit can stall on in-flight producers. It also reports how many destination writes are outstanding.

## Interface
- `XLEN`, 32, data width of each register
- `NREGS`, 32, number of architectural registers (power of two, ≥ 2)
- `AW`, $clog2(NREGS), register address width (derived, not overridden)
- `ZERO_REG`, 1, when 1 register 0 is hard-wired to zero and always ready

- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `rd_en`  in  1  capture read ports this cycle
- `ra1`, `ra2`  in  AW  read addresses
- `rd1`, `rd2`  out  XLEN  registered read data
- `rdy1`, `rdy2`  out  1  registered ready flag of the addressed register
- `iss_en`  in  1  issue: mark `iss_addr` pending (clear ready)
- `iss_addr`  in  AW  destination of the issued instruction
- `we`  in  1  write-back enable
- `wa`  in  AW  write-back address
- `wd`  in  XLEN  write-back data
- `pend_cnt`  out  AW+1  number of registers currently not ready

## Operation
- Storage:
  - `regs[NREGS]` of XLEN bits.
  - `ready[NREGS]` of 1 bit; 1 means the value is current.
- Reset (async):
  - All `regs` = 0, all `ready` = 1.
  - `rd1` = `rd2` = 0, `rdy1` = `rdy2` = 1, `pend_cnt` = 0.
- Write-back (`we`=1):
  - `regs[wa]` <= `wd` and `ready[wa]` <= 1.
  - Writing to an already-ready register is legal: data is updated and the flag stays 1.
- Issue (`iss_en`=1):
  - `ready[iss_addr]` <= 0.
  - Issuing to a register that is already pending is legal: the flag stays 0 and the count is unchanged.
- Simultaneous write-back and issue to the same address: data is written, and `ready` ends at 0 because the new producer wins.
- Simultaneous write-back and issue to different addresses: both take effect.
- Read (`rd_en`=1):
  - `rdN` <= post-update value of `regs[raN]` (write-first bypass: if `we` and `wa`==`raN`, `rdN` <= `wd`).
  - `rdyN` <= post-update value of `ready[raN]`, including the same-cycle issue/write-back effects above.
- `rd_en`=0: `rd1`, `rd2`, `rdy1`, `rdy2` hold their values.
- `ZERO_REG`=1:
  - Writes and issues to address 0 are ignored.
  - Reads of address 0 return 0 with ready 1.
- `pend_cnt`: registered count of zero `ready` bits. Per cycle it changes by +1, −1 or 0, derived from the issue-set and write-back-clear events above, with no double counting. Never exceeds NREGS−ZERO_REG.

## Timing
- Read latency: 1 cycle. Address presented in cycle N, data valid after edge N.
- Write visibility:
  - Same-cycle reads see it via bypass.
  - Later reads see it from storage.
- Issue visibility: a read in the same cycle as the issue already returns `rdy`=0.
- `pend_cnt` reflects all events of cycle N after edge N.
- Reset asserted mid-operation clears all state immediately, independent of `clk`. The first update happens on the first rising edge after deassertion.
- No combinational path from any input to any output.

## Structure
- Package `regfile_pkg`:
  - Constants `XLEN_DEF`, `NREGS_DEF`.
  - Typedefs `reg_addr_t` (AW bits) and `reg_data_t` (XLEN bits).
- Sub-module `regfile_rport`: one instance per read port. It contains the bypass mux, ready lookup and output registers, and is instantiated twice.
- Scoreboard update and `pend_cnt` logic live in the top level.

## Test plan
- Reset then `rd_en` with `ra1`=5, `ra2`=0:
  - `rd1`=0, `rdy1`=1, `rd2`=0, `rdy2`=1, `pend_cnt`=0.
- Issue x3:
  - Next cycle: read x3 gives `rdy1`=0, `pend_cnt`=1.
  - Then `we`, `wa`=3, `wd`=0xDEADBEEF with `ra1`=3 in the same cycle: `rd1`=0xDEADBEEF, `rdy1`=1, `pend_cnt`=0.
- Same-cycle `iss_en` x7 and `we` x7 with `wd`=0x55:
  - Read x7 gives 0x55 with `rdy`=0, `pend_cnt`=1.
- `we` to x0 with 0xFFFFFFFF plus `iss_en` x0:
  - Read x0 gives 0 with `rdy`=1, `pend_cnt` unchanged.
- Issue x1..x31 on consecutive cycles:
  - `pend_cnt` reaches 31 (saturation path).
  - Write back all 31 registers and `pend_cnt` returns to 0.
- `reset` pulsed between clock edges while `pend_cnt`=4 and `rd1`≠0:
  - All outputs return to reset values before the next edge.
